// File: rtl/elevator_request_queue_pkg.sv
// rtl/elevator_request_queue_pkg.sv - shared floor/direction encodings and floor helpers
package elevator_request_queue_pkg;

  localparam int MAX_FLOORS = 32;

  typedef enum logic [1:0] {
    DIR_STOP    = 2'd0,
    DIR_UP      = 2'd1,
    DIR_DOWN    = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_e;

  // Floor numbers are 1-based; 0 or anything past MAX_FLOORS yields an all-zero vector.
  function automatic logic [MAX_FLOORS-1:0] floor_onehot(input logic [MAX_FLOORS-1:0] n);
    if (n == '0) return '0;
    return MAX_FLOORS'(1) << (n - MAX_FLOORS'(1));
  endfunction

endpackage

// File: rtl/elevator_request_queue_if.sv
// rtl/elevator_request_queue_if.sv - request-queue link between queue writer and elevator controller
interface elevator_request_queue_if #(
  parameter int floor = 6
);

  logic [floor-1:0] queueUp;
  logic [floor-1:0] queueDown;
  logic [floor-1:0] queueinside;
  logic             pendingAny;
  logic             pendingAbove;
  logic             pendingBelow;
  logic [floor-1:0] currentFloor;
  logic             serviceValid;
  logic [1:0]       serviceDir;

  modport master (
    output queueUp, queueDown, queueinside, pendingAny, pendingAbove, pendingBelow,
    input  currentFloor, serviceValid, serviceDir
  );

  modport slave (
    input  queueUp, queueDown, queueinside, pendingAny, pendingAbove, pendingBelow,
    output currentFloor, serviceValid, serviceDir
  );

endinterface

// File: rtl/elevator_request_queue_button_conditioner.sv
// rtl/elevator_request_queue_button_conditioner.sv - synchronize, debounce and edge-detect one raw button
module button_conditioner #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      level       <= 1'b0;
      level_d     <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      level_d     <= level;
      press_pulse <= level & ~level_d;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/elevator_request_queue.sv
// rtl/elevator_request_queue.sv - latches conditioned hall/car calls and clears them on service
module elevator_request_queue
  import elevator_request_queue_pkg::*;
#(
  parameter int floor    = 6,
  parameter int DEBOUNCE = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [floor-1:0]         btnUp,
  input  logic [floor-1:0]         btnDown,
  input  logic [floor-1:0]         btnInside,
  elevator_request_queue_if.master rq
);

  // No up call from the top floor, no down call from the ground floor.
  localparam logic [floor-1:0] UP_MASK   = ~(floor'(1) << (floor - 1));
  localparam logic [floor-1:0] DOWN_MASK = ~floor'(1);

  logic [floor-1:0]      press_up, press_down, press_inside;
  logic [floor-1:0]      q_up, q_down, q_inside;
  logic [floor-1:0]      clr_up, clr_down, clr_inside;
  logic [floor-1:0]      f, all_q, below_mask, above_mask;
  logic [MAX_FLOORS-1:0] f_wide;
  logic                  in_range;
  dir_e                  dir;

  for (genvar i = 0; i < floor; i++) begin : g_btn
    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_up (
      .clock(clock), .reset_n(reset_n), .raw(btnUp[i]), .press_pulse(press_up[i])
    );
    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_down (
      .clock(clock), .reset_n(reset_n), .raw(btnDown[i]), .press_pulse(press_down[i])
    );
    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_inside (
      .clock(clock), .reset_n(reset_n), .raw(btnInside[i]), .press_pulse(press_inside[i])
    );
  end

  assign f_wide   = floor_onehot(MAX_FLOORS'(rq.currentFloor));
  assign f        = f_wide[floor-1:0];
  assign in_range = (f != '0) && (f_wide[MAX_FLOORS-1:floor] == '0);
  assign dir      = dir_e'(rq.serviceDir);

  always_comb begin
    clr_up     = '0;
    clr_down   = '0;
    clr_inside = '0;
    if (rq.serviceValid && in_range) begin
      case (dir)
        DIR_STOP: begin
          clr_up     = f;
          clr_down   = f;
          clr_inside = f;
        end
        DIR_UP: begin
          clr_up     = f;
          clr_inside = f;
        end
        DIR_DOWN: begin
          clr_down   = f;
          clr_inside = f;
        end
        default: ;
      endcase
    end
  end

  // Clear is applied after set so a press landing on the serviced floor is dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q_up     <= '0;
      q_down   <= '0;
      q_inside <= '0;
    end else begin
      q_up     <= (q_up | press_up) & ~clr_up & UP_MASK;
      q_down   <= (q_down | press_down) & ~clr_down & DOWN_MASK;
      q_inside <= (q_inside | press_inside) & ~clr_inside;
    end
  end

  assign all_q      = q_up | q_down | q_inside;
  assign below_mask = f - floor'(1);
  assign above_mask = ~(below_mask | f);

  assign rq.queueUp      = q_up;
  assign rq.queueDown    = q_down;
  assign rq.queueinside  = q_inside;
  assign rq.pendingAny   = |all_q;
  assign rq.pendingAbove = in_range && |(all_q & above_mask);
  assign rq.pendingBelow = in_range && |(all_q & below_mask);

endmodule
